mem_stage: RTL

Memory-access stage sitting directly downstream of the EX/MEM pipeline register. It turns the latched memory operation into a data-bus transaction with a req/ack handshake and stalls the front of the pipeline while the access is outstanding. It aligns store data into byte lanes and extracts and extends load data. It selects the write-back result and registers everything into the MEM/WB boundary.

---
 rtl/mem_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: turns the EX/MEM memory op into a req/ack bus transaction and fills MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module mem_stage (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clk_en,
   input  logic [4:0]  i_rd_m,
   input  logic [31:0] i_alu_out_m,
   input  logic [31:0] i_haz_b_m,
   input  logic [31:0] i_pc_p4_m,
   input  logic [31:0] i_old_csr_m,
   input  logic        i_reg_wr_m,
   input  logic [1:0]  i_result_src_m,
   input  logic        i_mem_write_m,
   input  logic [2:0]  i_f3_m,
   input  logic        i_store_byte_m,
   input  logic        i_store_half_m,
   output logic        o_dbus_req,
   output logic        o_dbus_we,
   output logic [31:0] o_dbus_addr,
   output logic [3:0]  o_dbus_be,
   output logic [31:0] o_dbus_wdata,
   input  logic        i_dbus_ack,
   input  logic [31:0] i_dbus_rdata,
   output logic        o_stall_m,
   output logic [4:0]  o_rd_w,
   output logic        o_reg_wr_w,
   output logic [31:0] o_result_w,
   output logic [3:0]  o_exception_code_w
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] rdata_q;

   logic        is_load_s;
   logic        is_store_s;
   logic        mem_op_s;
   logic        misalign_s;
   logic        mem_go_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;
   logic [7:0]  ld_byte_s;
   logic [15:0] ld_half_s;
   logic [31:0] load_val_s;
   logic [31:0] result_s;

   assign is_load_s  = (i_result_src_m == 2'b01);
   assign is_store_s = i_mem_write_m;
   assign mem_op_s   = is_load_s | is_store_s;

`ifdef MEM_MISALIGN_TRAP_EN
   logic half_acc_s;
   logic word_acc_s;

   // Classify access size; unlisted load f3 codes behave as word loads.
   always_comb begin
      half_acc_s = 1'b0;
      word_acc_s = 1'b0;
      if (is_store_s) begin
         half_acc_s = ~i_store_byte_m & i_store_half_m;
         word_acc_s = ~i_store_byte_m & ~i_store_half_m;
      end else begin
         half_acc_s = (i_f3_m == 3'b001) | (i_f3_m == 3'b101);
         word_acc_s = ~half_acc_s & (i_f3_m != 3'b000) & (i_f3_m != 3'b100);
      end
   end

   assign misalign_s = mem_op_s & ((half_acc_s & i_alu_out_m[0]) |
                                   (word_acc_s & (i_alu_out_m[1:0] != 2'b00)));
`else
   assign misalign_s = 1'b0;
`endif

   assign mem_go_s  = mem_op_s & ~misalign_s;
   assign o_stall_m = mem_go_s & (state_q != ST_DONE);

   // Store lane alignment: byte enables and replicated write data.
   always_comb begin
      be_s    = 4'b1111;
      wdata_s = i_haz_b_m;
      if (is_store_s) begin
         if (i_store_byte_m) begin
            be_s    = 4'b0001 << i_alu_out_m[1:0];
            wdata_s = {4{i_haz_b_m[7:0]}};
         end else if (i_store_half_m) begin
            be_s    = i_alu_out_m[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{i_haz_b_m[15:0]}};
         end else begin
            be_s    = 4'b1111;
            wdata_s = i_haz_b_m;
         end
      end else begin
         be_s    = 4'b1111;
         wdata_s = i_haz_b_m;
      end
   end

   // Load extraction from the captured bus word.
   always_comb begin
      case (i_alu_out_m[1:0])
         2'b00:   ld_byte_s = rdata_q[7:0];
         2'b01:   ld_byte_s = rdata_q[15:8];
         2'b10:   ld_byte_s = rdata_q[23:16];
         2'b11:   ld_byte_s = rdata_q[31:24];
         default: ld_byte_s = rdata_q[7:0];
      endcase
      ld_half_s = i_alu_out_m[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (i_f3_m)
         3'b000:  load_val_s = {{24{ld_byte_s[7]}}, ld_byte_s};
         3'b001:  load_val_s = {{16{ld_half_s[15]}}, ld_half_s};
         3'b100:  load_val_s = {24'd0, ld_byte_s};
         3'b101:  load_val_s = {16'd0, ld_half_s};
         default: load_val_s = rdata_q;
      endcase
   end

   // Write-back result select.
   always_comb begin
      case (i_result_src_m)
         2'b00:   result_s = i_alu_out_m;
         2'b01:   result_s = load_val_s;
         2'b10:   result_s = i_pc_p4_m;
         2'b11:   result_s = i_old_csr_m;
         default: result_s = i_alu_out_m;
      endcase
   end

   // Bus FSM with registered bus outputs; ack in BUS is taken even while the pipeline is frozen.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         rdata_q      <= 32'd0;
         o_dbus_req   <= 1'b0;
         o_dbus_we    <= 1'b0;
         o_dbus_addr  <= 32'd0;
         o_dbus_be    <= 4'd0;
         o_dbus_wdata <= 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_clk_en && mem_go_s) begin
                  o_dbus_req   <= 1'b1;
                  o_dbus_we    <= is_store_s;
                  o_dbus_addr  <= {i_alu_out_m[31:2], 2'b00};
                  o_dbus_be    <= be_s;
                  o_dbus_wdata <= wdata_s;
                  state_q      <= ST_BUS;
               end
            end
            ST_BUS: begin
               if (i_dbus_ack) begin
                  rdata_q    <= i_dbus_rdata;
                  o_dbus_req <= 1'b0;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_clk_en) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               o_dbus_req <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   // MEM/WB boundary register: bubble while stalled, trap record on a misaligned access.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rd_w             <= 5'd0;
         o_reg_wr_w         <= 1'b0;
         o_result_w         <= 32'd0;
         o_exception_code_w <= 4'b1111;
      end else if (i_clk_en) begin
         if (o_stall_m) begin
            o_rd_w             <= 5'd0;
            o_reg_wr_w         <= 1'b0;
            o_result_w         <= 32'd0;
            o_exception_code_w <= 4'b1111;
         end else if (misalign_s) begin
            o_rd_w             <= i_rd_m;
            o_reg_wr_w         <= 1'b0;
            o_result_w         <= i_alu_out_m;
            o_exception_code_w <= is_store_s ? 4'd6 : 4'd4;
         end else begin
            o_rd_w             <= i_rd_m;
            o_reg_wr_w         <= i_reg_wr_m;
            o_result_w         <= result_s;
            o_exception_code_w <= 4'b1111;
         end
      end
   end

endmodule
